// File: rtl/accumulate_unit_if.sv
// Argument and result streams of the signed accumulator.
// The master drives arguments and result acceptance; the slave is the accumulator.
interface accumulate_unit_if #(
    parameter int ARGW = 16,
    parameter int RESW = 2 * ARGW
);
    logic            arg_valid;
    logic            arg_ready;
    logic [ARGW-1:0] arg_data;
    logic            clr;
    logic            res_valid;
    logic            res_ready;
    logic [RESW-1:0] res_data;

    modport master (
        output arg_valid, arg_data, clr, res_ready,
        input  arg_ready, res_valid, res_data
    );

    modport slave (
        input  arg_valid, arg_data, clr, res_ready,
        output arg_ready, res_valid, res_data
    );
endinterface

// File: rtl/accumulate_unit.sv
// Streaming signed accumulator: each accepted argument is sign-extended and added
// to a RESW-bit running sum (wrapping), published through a single-entry result register.
module accumulate_unit #(
    parameter int ARGW = 16,
    parameter int RESW = 2 * ARGW
) (
    input  logic            clk,
    input  logic            rst,
    accumulate_unit_if.slave acc_if
);

    logic [RESW-1:0] acc_q;
    logic [RESW-1:0] acc_d;
    logic            res_valid_q;
    logic            res_valid_d;
    logic            arg_ready;
    logic            arg_fire;
    logic            res_fire;
    logic [RESW-1:0] arg_sext;

    // Ready depends only on the output register state and res_ready, never on arg_data.
    assign arg_ready = !res_valid_q || acc_if.res_ready;
    assign arg_fire  = acc_if.arg_valid && arg_ready;
    assign res_fire  = res_valid_q && acc_if.res_ready;
    assign arg_sext  = RESW'(signed'(acc_if.arg_data));

    always_comb begin
        acc_d       = acc_q;
        res_valid_d = res_valid_q;
        if (res_fire) begin
            res_valid_d = 1'b0;
        end
        // A new acceptance in the same cycle as a retire keeps the register full.
        if (arg_fire) begin
            res_valid_d = 1'b1;
            if (acc_if.clr) begin
                acc_d = arg_sext;
            end else begin
                acc_d = acc_q + arg_sext;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign acc_if.arg_ready = arg_ready;
    assign acc_if.res_valid = res_valid_q;
    assign acc_if.res_data  = acc_q;

endmodule

// File: tb/tb_accumulate_unit.sv
// Self-checking bench for accumulate_unit (ARGW=24, RESW=40) with a wrap-around
// arithmetic reference model and a handshake model for randomized traffic.
module tb_accumulate_unit;

    localparam int ARGW = 24;
    localparam int RESW = 40;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    logic [RESW-1:0] m_acc;
    logic            m_valid;

    accumulate_unit_if #(.ARGW(ARGW), .RESW(RESW)) bus ();

    accumulate_unit #(.ARGW(ARGW), .RESW(RESW)) dut (
        .clk    (clk),
        .rst    (rst),
        .acc_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, run did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [RESW-1:0] sext_arg(input logic [ARGW-1:0] a);
        logic signed [ARGW-1:0] s;
        longint v;
        s = a;
        v = s;
        return v[RESW-1:0];
    endfunction

    task automatic model_accept(input logic [ARGW-1:0] d, input logic c);
        longint sum;
        if (c) begin
            m_acc = sext_arg(d);
        end else begin
            sum   = longint'(m_acc) + longint'(sext_arg(d));
            m_acc = sum[RESW-1:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle argument pulse; caller guarantees arg_ready is high at that edge.
    task automatic send_arg(input logic [ARGW-1:0] d, input logic c);
        bus.arg_valid = 1'b1;
        bus.arg_data  = d;
        bus.clr       = c;
        step();
        bus.arg_valid = 1'b0;
        bus.clr       = 1'b0;
        model_accept(d, c);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.arg_valid = 1'b0;
        bus.arg_data  = '0;
        bus.clr       = 1'b0;
        bus.res_ready = 1'b1;
        m_acc         = '0;
        m_valid       = 1'b0;
        step();
        step();
        tests_run++;
        if (bus.res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_res_valid: got %b want 0", bus.res_valid);
        end
        tests_run++;
        if (bus.res_data !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_res_data: got %h want 0", bus.res_data);
        end
        tests_run++;
        if (bus.arg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_arg_ready: got %b want 1", bus.arg_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic(input string tag);
        logic [RESW-1:0] want [3];
        logic [ARGW-1:0] args [3];
        args[0] = 24'h0000FF; want[0] = 40'h00000000FF;
        args[1] = 24'h000001; want[1] = 40'h0000000100;
        args[2] = 24'hFFFFFF; want[2] = 40'h00000000FF;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_arg(args[i], 1'b0);
            tests_run++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== want[i]) begin
                tests_failed++;
                $display("FAIL %s_sum%0d: got valid=%b data=%h want valid=1 data=%h",
                         tag, i, bus.res_valid, bus.res_data, want[i]);
            end
        end
    endtask

    task automatic test_clear();
        bus.res_ready = 1'b1;
        send_arg(24'h00000F, 1'b1);
        tests_run++;
        if (bus.res_data !== 40'h000000000F) begin
            tests_failed++;
            $display("FAIL clear_load: got %h want 000000000f", bus.res_data);
        end
        send_arg(24'h000001, 1'b0);
        tests_run++;
        if (bus.res_data !== 40'h0000000010) begin
            tests_failed++;
            $display("FAIL clear_then_add: got %h want 0000000010", bus.res_data);
        end
    endtask

    task automatic test_reset_midstream();
        step();
        bus.res_ready = 1'b0;
        send_arg(24'h000001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 40'h0 || bus.arg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_async_clear: got valid=%b data=%h ready=%b want 0/0/1",
                     bus.res_valid, bus.res_data, bus.arg_ready);
        end
        step();
        rst           = 1'b0;
        m_acc         = '0;
        bus.res_ready = 1'b1;
        step();
        test_basic("after_reset");
    endtask

    task automatic test_backpressure();
        logic [ARGW-1:0] a;
        logic [ARGW-1:0] b;
        logic [RESW-1:0] held;
        a = 24'($urandom());
        b = 24'($urandom());
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        send_arg(a, 1'b0);
        held = m_acc;
        bus.arg_valid = 1'b1;
        bus.arg_data  = b;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (bus.arg_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== held) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got ready=%b valid=%b data=%h want 0/1/%h",
                         i, bus.arg_ready, bus.res_valid, bus.res_data, held);
            end
        end
        bus.res_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.arg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_ready: got %b want 1", bus.arg_ready);
        end
        step();
        bus.arg_valid = 1'b0;
        model_accept(b, 1'b0);
        tests_run++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== m_acc) begin
            tests_failed++;
            $display("FAIL stall_next_accept: got valid=%b data=%h want 1/%h",
                     bus.res_valid, bus.res_data, m_acc);
        end
        step();
        tests_run++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== m_acc) begin
            tests_failed++;
            $display("FAIL stall_single_result: got valid=%b data=%h want 0/%h",
                     bus.res_valid, bus.res_data, m_acc);
        end
    endtask

    task automatic test_wrap();
        bus.res_ready = 1'b1;
        bus.arg_valid = 1'b1;
        bus.clr       = 1'b1;
        bus.arg_data  = 24'h7FFFFF;
        step();
        model_accept(24'h7FFFFF, 1'b1);
        bus.clr = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            step();
            model_accept(24'h7FFFFF, 1'b0);
        end
        bus.arg_data = 24'h00FFFF;
        step();
        model_accept(24'h00FFFF, 1'b0);
        tests_run++;
        if (bus.res_data !== 40'h7FFFFFFFFF || bus.res_data !== m_acc) begin
            tests_failed++;
            $display("FAIL wrap_preload_max: got %h want 7fffffffff", bus.res_data);
        end
        bus.arg_data = 24'h000001;
        step();
        model_accept(24'h000001, 1'b0);
        tests_run++;
        if (bus.res_data !== 40'h8000000000) begin
            tests_failed++;
            $display("FAIL wrap_pos_to_neg: got %h want 8000000000", bus.res_data);
        end
        bus.clr      = 1'b1;
        bus.arg_data = 24'hFFFFFF;
        step();
        model_accept(24'hFFFFFF, 1'b1);
        tests_run++;
        if (bus.res_data !== 40'hFFFFFFFFFF) begin
            tests_failed++;
            $display("FAIL wrap_load_minus1: got %h want ffffffffff", bus.res_data);
        end
        bus.clr      = 1'b0;
        bus.arg_data = 24'h000001;
        step();
        model_accept(24'h000001, 1'b0);
        bus.arg_valid = 1'b0;
        tests_run++;
        if (bus.res_data !== 40'h0000000000) begin
            tests_failed++;
            $display("FAIL wrap_to_zero: got %h want 0000000000", bus.res_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [ARGW-1:0] d;
        logic            c;
        bus.res_ready = 1'b1;
        step();
        bus.arg_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 24'($urandom());
            c = ($urandom_range(0, 3) == 0);
            bus.arg_data = d;
            bus.clr      = c;
            step();
            model_accept(d, c);
            tests_run++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== m_acc) begin
                tests_failed++;
                $display("FAIL b2b_result%0d: got valid=%b data=%h want 1/%h",
                         i, bus.res_valid, bus.res_data, m_acc);
            end
        end
        bus.arg_valid = 1'b0;
        bus.clr       = 1'b0;
        step();
        tests_run++;
        if (bus.res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got valid=%b want 0", bus.res_valid);
        end
        bus.clr      = 1'b1;
        bus.arg_data = 24'($urandom());
        step();
        bus.clr = 1'b0;
        tests_run++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== m_acc) begin
            tests_failed++;
            $display("FAIL clr_without_valid: got valid=%b data=%h want 0/%h",
                     bus.res_valid, bus.res_data, m_acc);
        end
        send_arg(24'h000003, 1'b0);
        tests_run++;
        if (bus.res_data !== m_acc) begin
            tests_failed++;
            $display("FAIL clr_without_valid_continue: got %h want %h", bus.res_data, m_acc);
        end
    endtask

    task automatic test_random_traffic();
        logic            av;
        logic            rr;
        logic            c;
        logic [ARGW-1:0] d;
        logic            exp_ready;
        bus.arg_valid = 1'b0;
        bus.res_ready = 1'b1;
        step();
        m_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            av = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 7) == 0);
            d  = 24'($urandom());
            bus.arg_valid = av;
            bus.res_ready = rr;
            bus.clr       = c;
            bus.arg_data  = d;
            #3;
            exp_ready = !m_valid || rr;
            tests_run++;
            if (bus.arg_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rand_ready%0d: got %b want %b", i, bus.arg_ready, exp_ready);
            end
            if (av && exp_ready) begin
                model_accept(d, c);
                m_valid = 1'b1;
            end else if (m_valid && rr) begin
                m_valid = 1'b0;
            end
            step();
            tests_run++;
            if (bus.res_valid !== m_valid || bus.res_data !== m_acc) begin
                tests_failed++;
                $display("FAIL rand_out%0d: got valid=%b data=%h want %b/%h",
                         i, bus.res_valid, bus.res_data, m_valid, m_acc);
            end
        end
        bus.arg_valid = 1'b0;
        bus.clr       = 1'b0;
        bus.res_ready = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic("basic");
        test_clear();
        test_reset_midstream();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
